// File: rtl/fpsu_sched_pkg.sv
// Shared types and constants for the FP add/sub writeback-slot scheduler.
package fpsu_sched_pkg;

    localparam int SLOT_TAGW = 14;
    localparam int LAT_MAX   = 4;

    localparam logic [1:0] LAT1 = 2'b00;
    localparam logic [1:0] LAT2 = 2'b01;
    localparam logic [1:0] LAT3 = 2'b10;
    localparam logic [1:0] LAT4 = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_TAGW-1:0] tag;
    } slot_t;

    function automatic logic [2:0] lat_code_to_cycles(input logic [1:0] code);
        case (code)
            LAT1:    return 3'd1;
            LAT2:    return 3'd2;
            LAT3:    return 3'd3;
            LAT4:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/fpsu_wb_port.sv
// One datapath port: result-slot shift line, eligibility check, primary/alternate
// round-robin arbiter and registered return bus.
module fpsu_wb_port
    import fpsu_sched_pkg::*;
#(
    parameter int MAXLAT = LAT_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 p_req,
    input  logic [1:0]           p_lat,
    input  logic [SLOT_TAGW-1:0] p_tag,
    input  logic                 a_req,
    input  logic [1:0]           a_lat,
    input  logic [SLOT_TAGW-1:0] a_tag,
    output logic                 p_gnt,
    output logic                 a_gnt,
    output logic [SLOT_TAGW-1:0] ret,
    output logic                 ret_en,
    output logic                 busy
);

    slot_t                slot_q [1:MAXLAT];
    slot_t                slot_d [1:MAXLAT];
    logic [MAXLAT:1]      blocked;
    logic [2:0]           p_cyc;
    logic [2:0]           a_cyc;
    logic                 p_elig;
    logic                 a_elig;
    logic                 rr_q;
    logic                 rr_d;
    logic [SLOT_TAGW-1:0] ret_q;
    logic [SLOT_TAGW-1:0] ret_d;
    logic                 ret_en_q;
    logic                 ret_en_d;

    always_comb begin
        // Latency L is blocked when slot[L+1] is live: it shifts into slot[L] this edge.
        blocked = '0;
        busy    = 1'b0;
        for (int k = 1; k < MAXLAT; k++) begin
            blocked[k] = slot_q[k+1].valid;
        end
        for (int k = 1; k <= MAXLAT; k++) begin
            busy = busy | slot_q[k].valid;
        end

        p_cyc  = lat_code_to_cycles(p_lat);
        a_cyc  = lat_code_to_cycles(a_lat);
        p_elig = p_req && !blocked[p_cyc];
        a_elig = a_req && !blocked[a_cyc];

        p_gnt  = !flush && p_elig && (!a_elig || !rr_q);
        a_gnt  = !flush && a_elig && (!p_elig || rr_q);
        rr_d   = rr_q ^ (!flush && p_elig && a_elig);

        for (int k = 1; k < MAXLAT; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        slot_d[MAXLAT] = '0;
        if (p_gnt) begin
            slot_d[p_cyc] = {1'b1, p_tag};
        end
        if (a_gnt) begin
            slot_d[a_cyc] = {1'b1, a_tag};
        end

        ret_en_d = slot_q[1].valid && !flush;
        ret_d    = ret_en_d ? slot_q[1].tag : '0;

        if (flush) begin
            for (int k = 1; k <= MAXLAT; k++) begin
                slot_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= MAXLAT; k++) begin
                slot_q[k] <= '0;
            end
            rr_q     <= 1'b0;
            ret_q    <= '0;
            ret_en_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            rr_q     <= rr_d;
            ret_q    <= ret_d;
            ret_en_q <= ret_en_d;
        end
    end

    assign ret    = ret_q;
    assign ret_en = ret_en_q;

endmodule

// File: rtl/fpsu_wb_sched.sv
// Writeback-slot scheduler for the u1/u3/u5 FP add/sub ports; one independent
// fpsu_wb_port per port, flush shared. TAGW must equal SLOT_TAGW.
module fpsu_wb_sched
    import fpsu_sched_pkg::*;
#(
    parameter int NPORT  = 3,
    parameter int TAGW   = SLOT_TAGW,
    parameter int MAXLAT = LAT_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORT-1:0]      p_req,
    input  logic [2*NPORT-1:0]    p_lat,
    input  logic [TAGW*NPORT-1:0] p_tag,
    input  logic [NPORT-1:0]      a_req,
    input  logic [2*NPORT-1:0]    a_lat,
    input  logic [TAGW*NPORT-1:0] a_tag,
    input  logic                  flush,
    output logic [NPORT-1:0]      p_gnt,
    output logic [NPORT-1:0]      a_gnt,
    output logic [TAGW*NPORT-1:0] ret,
    output logic [NPORT-1:0]      ret_en,
    output logic [NPORT-1:0]      busy
);

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        fpsu_wb_port #(
            .MAXLAT (MAXLAT)
        ) u_port (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .p_req  (p_req[p]),
            .p_lat  (p_lat[2*p +: 2]),
            .p_tag  (p_tag[TAGW*p +: TAGW]),
            .a_req  (a_req[p]),
            .a_lat  (a_lat[2*p +: 2]),
            .a_tag  (a_tag[TAGW*p +: TAGW]),
            .p_gnt  (p_gnt[p]),
            .a_gnt  (a_gnt[p]),
            .ret    (ret[TAGW*p +: TAGW]),
            .ret_en (ret_en[p]),
            .busy   (busy[p])
        );
    end

endmodule

// File: tb/tb_fpsu_wb_sched.sv
// Bench for fpsu_wb_sched: directed scenarios plus a randomized run against a
// reservation-table model (each op is a tag due at an absolute return cycle).
module tb_fpsu_wb_sched;

    localparam int NPORT = 3;
    localparam int TAGW  = 14;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NPORT-1:0]      p_req, a_req;
    logic [2*NPORT-1:0]    p_lat, a_lat;
    logic [TAGW*NPORT-1:0] p_tag, a_tag;
    logic                  flush;
    logic [NPORT-1:0]      p_gnt, a_gnt, ret_en, busy;
    logic [TAGW*NPORT-1:0] ret;

    fpsu_wb_sched #(.NPORT(NPORT), .TAGW(TAGW), .MAXLAT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .p_req  (p_req),
        .p_lat  (p_lat),
        .p_tag  (p_tag),
        .a_req  (a_req),
        .a_lat  (a_lat),
        .a_tag  (a_tag),
        .flush  (flush),
        .p_gnt  (p_gnt),
        .a_gnt  (a_gnt),
        .ret    (ret),
        .ret_en (ret_en),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [TAGW-1:0] tag;
    } op_t;

    op_t pend_q [NPORT][$];
    bit  rr_m   [NPORT];
    bit  both_m [NPORT];
    int  cyc;
    int  checks = 0;
    int  errors = 0;

    logic [NPORT-1:0]      exp_p_gnt, exp_a_gnt, exp_ret_en, exp_busy;
    logic [TAGW*NPORT-1:0] exp_ret;

    function automatic bit reserved(int p, int due);
        for (int i = 0; i < pend_q[p].size(); i++)
            if (pend_q[p][i].due == due) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPORT; p++) begin
            pend_q[p].delete();
            rr_m[p] = 1'b0;
        end
        cyc = 0;
    endtask

    task automatic model_eval();
        for (int p = 0; p < NPORT; p++) begin
            int lp, la;
            bit pok, aok;
            exp_ret_en[p] = 1'b0;
            exp_busy[p]   = 1'b0;
            exp_ret[TAGW*p +: TAGW] = '0;
            for (int i = 0; i < pend_q[p].size(); i++) begin
                if (pend_q[p][i].due == cyc) begin
                    exp_ret_en[p] = 1'b1;
                    exp_ret[TAGW*p +: TAGW] = pend_q[p][i].tag;
                end else if (pend_q[p][i].due > cyc) begin
                    exp_busy[p] = 1'b1;
                end
            end
            lp  = int'(p_lat[2*p +: 2]) + 1;
            la  = int'(a_lat[2*p +: 2]) + 1;
            pok = p_req[p] && !reserved(p, cyc + lp + 1);
            aok = a_req[p] && !reserved(p, cyc + la + 1);
            exp_p_gnt[p] = !flush && pok && (!aok || !rr_m[p]);
            exp_a_gnt[p] = !flush && aok && (!pok || rr_m[p]);
            both_m[p]    = !flush && pok && aok;
        end
    endtask

    task automatic model_commit();
        for (int p = 0; p < NPORT; p++) begin
            op_t op;
            op_t keep[$];
            if (exp_p_gnt[p]) begin
                op.due = cyc + int'(p_lat[2*p +: 2]) + 2;
                op.tag = p_tag[TAGW*p +: TAGW];
                pend_q[p].push_back(op);
            end
            if (exp_a_gnt[p]) begin
                op.due = cyc + int'(a_lat[2*p +: 2]) + 2;
                op.tag = a_tag[TAGW*p +: TAGW];
                pend_q[p].push_back(op);
            end
            if (both_m[p]) rr_m[p] = !rr_m[p];
            for (int i = 0; i < pend_q[p].size(); i++)
                if (pend_q[p][i].due > cyc && !flush) keep.push_back(pend_q[p][i]);
            pend_q[p] = keep;
        end
    endtask

    task automatic clear_inputs();
        p_req = '0; a_req = '0; p_lat = '0; a_lat = '0;
        p_tag = '0; a_tag = '0; flush = 1'b0;
    endtask

    task automatic set_p(int p, logic [1:0] lat, logic [TAGW-1:0] tag);
        p_req[p] = 1'b1;
        p_lat[2*p +: 2] = lat;
        p_tag[TAGW*p +: TAGW] = tag;
    endtask

    task automatic set_a(int p, logic [1:0] lat, logic [TAGW-1:0] tag);
        a_req[p] = 1'b1;
        a_lat[2*p +: 2] = lat;
        a_tag[TAGW*p +: TAGW] = tag;
    endtask

    // Inputs already applied; settle and compute the model's view of this cycle.
    task automatic drive_cycle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        clear_inputs();
        drive_cycle();
        checks++; if (ret_en !== '0) begin errors++; $display("FAIL reset_ret_en got=%b exp=0", ret_en); end
        checks++; if (ret !== '0) begin errors++; $display("FAIL reset_ret got=%h exp=0", ret); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ((p_gnt | a_gnt) !== '0) begin errors++; $display("FAIL reset_gnt got=%b/%b exp=0", p_gnt, a_gnt); end
        advance();
    endtask

    task automatic test_single_issue();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            logic [TAGW-1:0] et;
            clear_inputs();
            if (c == 0) set_p(0, 2'b01, 14'h005);
            drive_cycle();
            et = (c == 3) ? 14'h005 : 14'h000;
            if (c == 0) begin
                checks++; if (p_gnt[0] !== 1'b1) begin errors++; $display("FAIL single_gnt got=%b exp=1", p_gnt[0]); end
            end
            checks++; if (ret_en[0] !== (c == 3)) begin errors++; $display("FAIL single_ret_en cyc=%0d got=%b exp=%b", c, ret_en[0], c == 3); end
            checks++; if (ret[TAGW-1:0] !== et) begin errors++; $display("FAIL single_ret cyc=%0d got=%h exp=%h", c, ret[TAGW-1:0], et); end
            checks++; if (busy[0] !== (c == 1 || c == 2)) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy[0], c == 1 || c == 2); end
            advance();
        end
    endtask

    task automatic test_conflict();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            logic [TAGW-1:0] et;
            clear_inputs();
            if (c == 0) set_p(1, 2'b11, 14'h0A0);
            if (c == 1 || c == 2) set_p(1, 2'b10, 14'h0B0);
            drive_cycle();
            if (c <= 2) begin
                checks++; if (p_gnt[1] !== (c != 1)) begin errors++; $display("FAIL conflict_gnt cyc=%0d got=%b exp=%b", c, p_gnt[1], c != 1); end
            end
            et = (c == 5) ? 14'h0A0 : (c == 6) ? 14'h0B0 : 14'h000;
            checks++; if (ret_en[1] !== (c == 5 || c == 6)) begin errors++; $display("FAIL conflict_ret_en cyc=%0d got=%b", c, ret_en[1]); end
            checks++; if (ret[2*TAGW-1:TAGW] !== et) begin errors++; $display("FAIL conflict_ret cyc=%0d got=%h exp=%h", c, ret[2*TAGW-1:TAGW], et); end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            logic [TAGW-1:0] et;
            int g;
            clear_inputs();
            if (c < 8) begin
                set_p(2, 2'b00, 14'(16'h100 + c));
                set_a(2, 2'b00, 14'(16'h200 + c));
            end
            drive_cycle();
            g  = c - 2;
            et = (c < 2 || c >= 10) ? 14'h000 : (g % 2 == 0) ? 14'(16'h100 + g) : 14'(16'h200 + g);
            checks++; if (p_gnt[2] !== (c < 8 && c % 2 == 0)) begin errors++; $display("FAIL b2b_p_gnt cyc=%0d got=%b", c, p_gnt[2]); end
            checks++; if (a_gnt[2] !== (c < 8 && c % 2 == 1)) begin errors++; $display("FAIL b2b_a_gnt cyc=%0d got=%b", c, a_gnt[2]); end
            checks++; if (ret_en[2] !== (c >= 2 && c < 10)) begin errors++; $display("FAIL b2b_ret_en cyc=%0d got=%b", c, ret_en[2]); end
            checks++; if (ret[3*TAGW-1:2*TAGW] !== et) begin errors++; $display("FAIL b2b_ret cyc=%0d got=%h exp=%h", c, ret[3*TAGW-1:2*TAGW], et); end
            advance();
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            clear_inputs();
            if (c == 0) set_p(0, 2'b11, 14'h0C0);
            if (c == 2) begin
                flush = 1'b1;
                set_p(0, 2'b00, 14'h0D0);
            end
            drive_cycle();
            if (c == 0 || c == 2) begin
                checks++; if (p_gnt[0] !== (c == 0)) begin errors++; $display("FAIL flush_gnt cyc=%0d got=%b exp=%b", c, p_gnt[0], c == 0); end
            end
            checks++; if (busy[0] !== (c == 1 || c == 2)) begin errors++; $display("FAIL flush_busy cyc=%0d got=%b", c, busy[0]); end
            checks++; if (ret_en[0] !== 1'b0) begin errors++; $display("FAIL flush_ret_en cyc=%0d got=%b exp=0", c, ret_en[0]); end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        clear_inputs();
        for (int p = 0; p < NPORT; p++) set_p(p, 2'b11, 14'(16'h300 + p));
        drive_cycle();
        advance();
        clear_inputs();
        drive_cycle();
        advance();
        drive_cycle();
        checks++; if (busy !== 3'b111) begin errors++; $display("FAIL arst_busy_before got=%b exp=111", busy); end
        #1 rst = 1'b0;
        #1;
        checks++; if (busy !== '0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (ret_en !== '0) begin errors++; $display("FAIL arst_ret_en got=%b exp=0", ret_en); end
        checks++; if (ret !== '0) begin errors++; $display("FAIL arst_ret got=%h exp=0", ret); end
        #1 rst = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            if (c < 2) begin
                for (int p = 0; p < NPORT; p++) begin
                    set_p(p, 2'b00, 14'(16'h400 + c));
                    set_a(p, 2'b00, 14'(16'h500 + c));
                end
            end
            drive_cycle();
            if (c < 2) begin
                checks++; if (p_gnt !== ((c == 0) ? 3'b111 : 3'b000)) begin errors++; $display("FAIL arst_p_gnt cyc=%0d got=%b", c, p_gnt); end
                checks++; if (a_gnt !== ((c == 1) ? 3'b111 : 3'b000)) begin errors++; $display("FAIL arst_a_gnt cyc=%0d got=%b", c, a_gnt); end
            end
            checks++; if (ret_en !== ((c >= 2) ? 3'b111 : 3'b000)) begin errors++; $display("FAIL arst_ret_en_after cyc=%0d got=%b", c, ret_en); end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            clear_inputs();
            p_req = 3'($urandom);
            a_req = 3'($urandom);
            p_lat = 6'($urandom);
            a_lat = 6'($urandom);
            p_tag = 42'({$urandom, $urandom});
            a_tag = 42'({$urandom, $urandom});
            flush = ($urandom_range(0, 19) == 0);
            drive_cycle();
            checks++; if (p_gnt !== exp_p_gnt) begin errors++; $display("FAIL rand_p_gnt cyc=%0d got=%b exp=%b", cyc, p_gnt, exp_p_gnt); end
            checks++; if (a_gnt !== exp_a_gnt) begin errors++; $display("FAIL rand_a_gnt cyc=%0d got=%b exp=%b", cyc, a_gnt, exp_a_gnt); end
            checks++; if (ret_en !== exp_ret_en) begin errors++; $display("FAIL rand_ret_en cyc=%0d got=%b exp=%b", cyc, ret_en, exp_ret_en); end
            checks++; if (ret !== exp_ret) begin errors++; $display("FAIL rand_ret cyc=%0d got=%h exp=%h", cyc, ret, exp_ret); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            advance();
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single_issue();
        test_conflict();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
